// File: rtl/gf2_vec_packer.sv
// gf2_vec_packer: packs N_VEC vectors of VEC_W bits into one registered word.
// Optional running-XOR self-check output when GF2_PACK_XOR_CHECK_EN is defined.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   flush              sync discard of partial/full word
//   in_valid/in_ready  input handshake, in_vec lands in slot fill_cnt
//   out_valid/ready    output handshake for out_vectors
//   out_vectors        packed word, vector k at [k*VEC_W +: VEC_W]
//   fill_cnt           vectors captured in current word (0..N_VEC)
//   out_xor            XOR of vectors in current word (GF2_PACK_XOR_CHECK_EN)
module gf2_vec_packer #(
    parameter  int N_VEC = 3,
    parameter  int VEC_W = 35,
    localparam int CNT_W = $clog2(N_VEC + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [VEC_W-1:0]       in_vec,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_VEC*VEC_W-1:0] out_vectors,
    output logic [CNT_W-1:0]       fill_cnt
`ifdef GF2_PACK_XOR_CHECK_EN
    ,
    output logic [VEC_W-1:0]       out_xor
`endif
);

    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         fill_cnt_q, fill_cnt_d;
    logic [N_VEC*VEC_W-1:0]   out_vectors_q, out_vectors_d;

    logic                     in_fire;
    logic                     out_fire;
    logic [CNT_W-1:0]         slot_idx;
    logic                     first_vec;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FILL;
            fill_cnt_q    <= '0;
            out_vectors_q <= '0;
        end else begin
            state_q       <= state_d;
            fill_cnt_q    <= fill_cnt_d;
            out_vectors_q <= out_vectors_d;
        end
    end

    // Output / handshake logic
    always_comb begin
        out_valid = (state_q == S_FULL);
        // rst_n gates ready so nothing is offered while reset is held
        in_ready  = rst_n & ~flush & ((state_q == S_FILL) | out_ready);
        in_fire   = in_valid & in_ready;
        out_fire  = out_valid & out_ready;
        // A fire in FULL implies out_fire and starts the next word at slot 0
        slot_idx  = (state_q == S_FULL) ? '0 : fill_cnt_q;
        first_vec = (slot_idx == '0);
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        if (flush) begin
            state_d    = S_FILL;
            fill_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_FILL: begin
                    if (in_fire) begin
                        fill_cnt_d = fill_cnt_q + CNT_W'(1);
                        if (fill_cnt_q == CNT_W'(N_VEC - 1)) begin
                            state_d = S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (out_fire) begin
                        state_d    = S_FILL;
                        fill_cnt_d = in_fire ? CNT_W'(1) : '0;
                    end
                end
                default: begin
                    state_d    = S_FILL;
                    fill_cnt_d = '0;
                end
            endcase
        end
    end

    // Slot write: untouched slots keep stale data until flush/reset
    always_comb begin
        out_vectors_d = out_vectors_q;
        if (flush) begin
            out_vectors_d = '0;
        end else if (in_fire) begin
            for (int k = 0; k < N_VEC; k++) begin
                if (slot_idx == CNT_W'(k)) begin
                    out_vectors_d[k*VEC_W +: VEC_W] = in_vec;
                end
            end
        end
    end

    assign out_vectors = out_vectors_q;
    assign fill_cnt    = fill_cnt_q;

`ifdef GF2_PACK_XOR_CHECK_EN
    logic [VEC_W-1:0] out_xor_q, out_xor_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_xor_q <= '0;
        end else begin
            out_xor_q <= out_xor_d;
        end
    end

    // First vector of a word reloads, later ones accumulate
    always_comb begin
        out_xor_d = out_xor_q;
        if (flush) begin
            out_xor_d = '0;
        end else if (in_fire) begin
            out_xor_d = first_vec ? in_vec : (out_xor_q ^ in_vec);
        end
    end

    assign out_xor = out_xor_q;
`else
    logic unused_first;
    assign unused_first = first_vec;
`endif

endmodule

// File: tb/tb_gf2_vec_packer.sv
// tb_gf2_vec_packer: randomized + directed bench for gf2_vec_packer
// against a queue-based reference packer.
module tb_gf2_vec_packer;

    localparam int N = 3;
    localparam int W = 35;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [N*W-1:0]   out_vectors;
    logic [1:0]       fill_cnt;
`ifdef GF2_PACK_XOR_CHECK_EN
    logic [W-1:0]     out_xor;
`endif

    gf2_vec_packer #(.N_VEC(N), .VEC_W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_vec      (in_vec),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_vectors (out_vectors),
        .fill_cnt    (fill_cnt)
`ifdef GF2_PACK_XOR_CHECK_EN
        ,
        .out_xor     (out_xor)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference: accepted vectors gather in acc; complete words queue up
    logic [W-1:0]   acc[$];
    logic [N*W-1:0] exp_words[$];
    int             words_done = 0;
    bit             post_flush = 0;

    task automatic chk(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] word_xor(input logic [N*W-1:0] w);
        logic [W-1:0] x = '0;
        for (int i = 0; i < N; i++) x ^= w[i*W +: W];
        return x;
    endfunction

    function automatic logic [W-1:0] rnd_vec();
        logic [63:0] r = {$urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    // Called at posedge+1; checks at negedge, model update at posedge
    task automatic step(input logic fl, input logic iv,
                        input logic [W-1:0] v, input logic ordy);
        bit exp_full;
        bit exp_rdy;
        int exp_cnt;
        flush     = fl;
        in_valid  = iv;
        in_vec    = v;
        out_ready = ordy;
        #4;
        exp_full = (exp_words.size() != 0);
        exp_rdy  = !fl && (!exp_full || ordy);
        exp_cnt  = exp_full ? N : acc.size();
        chk("in_ready", 128'(in_ready), 128'(exp_rdy));
        chk("out_valid", 128'(out_valid), 128'(exp_full));
        chk("fill_cnt", 128'(fill_cnt), 128'(exp_cnt));
        if (exp_full && out_valid) begin
            chk("word", 128'(out_vectors), 128'(exp_words[0]));
`ifdef GF2_PACK_XOR_CHECK_EN
            chk("xor", 128'(out_xor), 128'(word_xor(exp_words[0])));
`endif
        end
        if (post_flush) begin
            chk("flush_zero", 128'(out_vectors), 128'(0));
`ifdef GF2_PACK_XOR_CHECK_EN
            chk("flush_xor", 128'(out_xor), 128'(0));
`endif
        end
        @(posedge clk);
        post_flush = fl;
        if (fl) begin
            acc.delete();
            exp_words.delete();
        end else begin
            if (exp_full && ordy) begin
                void'(exp_words.pop_front());
                words_done++;
            end
            if (iv && exp_rdy) begin
                acc.push_back(v);
                if (acc.size() == N) begin
                    exp_words.push_back({acc[2], acc[1], acc[0]});
                    acc.delete();
                end
            end
        end
        #1;
    endtask

    initial begin
        logic [N*W-1:0] held;
        int cyc;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_vec = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 128'(in_ready), 128'(0));
        chk("rst_valid", 128'(out_valid), 128'(0));
        rst_n = 1'b1;

        // Basic pack
        step(0, 1, 35'h1, 1);
        step(0, 1, 35'h2, 1);
        step(0, 1, 35'h4, 1);
        chk("basic_valid", 128'(out_valid), 128'(1));
        chk("basic_word", 128'(out_vectors), 128'({35'h4, 35'h2, 35'h1}));
`ifdef GF2_PACK_XOR_CHECK_EN
        chk("basic_xor", 128'(out_xor), 128'(7));
`endif
        step(0, 0, '0, 1);

        // Backpressure then same-cycle capture
        step(0, 1, 35'h11, 1);
        step(0, 1, 35'h22, 1);
        step(0, 1, 35'h33, 1);
        held = out_vectors;
        for (int i = 0; i < 5; i++) step(0, 1, rnd_vec(), 0);
        chk("bp_hold", 128'(out_vectors), 128'(held));
        step(0, 1, 35'h7FFFFFFFF, 1);
        step(0, 0, '0, 0);
        chk("bp_cnt", 128'(fill_cnt), 128'(1));
        chk("bp_slot0", 128'(out_vectors[W-1:0]), 128'(35'h7FFFFFFFF));

        // Flush at fill_cnt=2
        step(0, 1, 35'h5, 0);
        chk("pre_flush_cnt", 128'(fill_cnt), 128'(2));
        step(1, 1, 35'h9, 1);
        step(0, 1, 35'h100, 1);
        step(0, 1, 35'h200, 1);
        step(0, 1, 35'h300, 1);
        chk("clean_word", 128'(out_vectors),
            128'({35'h300, 35'h200, 35'h100}));
        // Flush in FULL with out_ready=1: word dropped
        step(1, 1, 35'h9, 1);
        chk("flush_drop", 128'(words_done), 128'(2));

        // Full-range placement
        step(0, 1, 35'h7FFFFFFFF, 1);
        step(0, 1, 35'h0, 1);
        step(0, 1, 35'h555555555, 1);
        chk("b34", 128'(out_vectors[34]), 128'(1));
        chk("b35", 128'(out_vectors[35]), 128'(0));
        chk("b69", 128'(out_vectors[69]), 128'(0));
        chk("b70", 128'(out_vectors[70]), 128'(1));
        step(0, 0, '0, 1);

        // Random traffic
        cyc = 0;
        words_done = 0;
        while (words_done < 1000 && cyc < 20000) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) != 0),
                 rnd_vec(),
                 ($urandom_range(0, 3) != 0));
            cyc++;
        end
        chk("rand_words", 128'(words_done >= 1000), 128'(1));

        // Reset mid-word
        step(0, 1, 35'h3, 1);
        step(0, 1, 35'h6, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_cnt", 128'(fill_cnt), 128'(0));
        chk("mid_rst_vec", 128'(out_vectors), 128'(0));
        chk("mid_rst_ready", 128'(in_ready), 128'(0));
        acc.delete();
        exp_words.delete();
        post_flush = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 0, '0, 0);
        step(0, 1, 35'hA, 1);
        step(0, 1, 35'hB, 1);
        step(0, 1, 35'hC, 1);
        step(0, 0, '0, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
